uart_tx_framed: RTL and testbench

Parametrised, buffered UART transmitter. Successor to the fixed 8N1 transmitter: configurable data width, runtime-selectable parity and stop-bit count, and a small input FIFO behind a valid/ready handshake. Frames are sent back-to-back with no idle gap. It sits between the core's I/O bus bridge and the board TX pin, and shares the same fractional baud accumulator scheme as the other UART blocks.

---
 rtl/uart_tx_framed.sv | 230 +++++++++++++++++++++++
 tb/tb_uart_tx_framed.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framed.sv
`default_nettype none
// ============================================================================
// uart_tx_framed : buffered UART transmitter (DATA_BITS data, opt. parity, 1/2 stop)
// Parity generation is built only when UART_TX_PARITY_EN is defined.
// Revision 1.0
// ============================================================================
module uart_tx_framed #(
   parameter int BAUD              = 115200,
   parameter int SOURCE_FREQ       = 25000000,
   parameter int ACCUMULATOR_WIDTH = 16,
   parameter int DATA_BITS         = 8,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                          sourceClk,
   input  logic                          reset,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx_out,
   output logic                          tx_busy,
   output logic                          tx_complete,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int W     = ACCUMULATOR_WIDTH;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam longint INC_L = ((longint'(BAUD) << (W - 4)) + (longint'(SOURCE_FREQ) >> 5))
                              / (longint'(SOURCE_FREQ) >> 4);
   localparam logic [W:0] INC       = (W + 1)'(INC_L);
   localparam logic [W:0] FRAC_MASK = {1'b0, {W{1'b1}}};
   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   // ------------------------------------------------------------------ FIFO
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [LVL_W-1:0]     level;
   logic                 push;
   logic                 pop;
   logic                 fifo_empty;

   assign tx_ready   = (level != FULL_LEVEL);
   assign push       = tx_valid && tx_ready;
   assign fifo_empty = (level == '0);
   assign fifo_level = level;

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge sourceClk) begin
      if (push) mem[wr_ptr] <= tx_data;
   end

   // ------------------------------------------------------- baud generator
   state_t     state;
   state_t     state_nxt;
   state_t     after_data;
   logic [W:0] acc;
   logic [W:0] acc_sum;
   logic       tick;

   // Carry out of the fractional sum marks the bit boundary; remainder is kept.
   assign acc_sum = (acc & FRAC_MASK) + INC;
   assign tick    = acc_sum[W];

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         acc <= '0;
      end else if (pop && (state == IDLE)) begin
         acc <= '0;
      end else begin
         acc <= acc_sum;
      end
   end

   // ---------------------------------------------------------------- parity
`ifdef UART_TX_PARITY_EN
   logic par_en;
   logic par_bit;

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         par_en  <= 1'b0;
         par_bit <= 1'b0;
      end else if (pop) begin
         par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
         par_bit <= (^mem[rd_ptr]) ^ (cfg_parity == 2'b10);
      end
   end

   assign after_data = par_en ? PARITY : STOP;
`else
   logic unused_cfg_parity;
   assign unused_cfg_parity = ^cfg_parity;
   assign after_data        = STOP;
`endif

   // ------------------------------------------------------------ frame FSM
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shift_nxt;
   logic [3:0]           bit_cnt;
   logic [3:0]           bit_cnt_nxt;
   logic                 stop_extra;
   logic                 stop_extra_nxt;
   logic                 stop2_lat;
   logic                 frame_done;
   logic                 tx_out_nxt;

   always_ff @(posedge sourceClk) begin
      if (!reset) begin
         state       <= IDLE;
         shift       <= '0;
         bit_cnt     <= '0;
         stop_extra  <= 1'b0;
         stop2_lat   <= 1'b0;
         tx_out      <= 1'b1;
         tx_complete <= 1'b0;
      end else begin
         state       <= state_nxt;
         shift       <= shift_nxt;
         bit_cnt     <= bit_cnt_nxt;
         stop_extra  <= stop_extra_nxt;
         tx_out      <= tx_out_nxt;
         tx_complete <= frame_done;
         if (pop) stop2_lat <= cfg_stop2;
      end
   end

   always_comb begin
      state_nxt      = state;
      shift_nxt      = shift;
      bit_cnt_nxt    = bit_cnt;
      stop_extra_nxt = stop_extra;
      pop            = 1'b0;
      frame_done     = 1'b0;

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop       = 1'b1;
               shift_nxt = mem[rd_ptr];
               state_nxt = START;
            end
         end
         START: begin
            if (tick) begin
               bit_cnt_nxt = '0;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shift_nxt = shift >> 1;
               if (bit_cnt == LAST_BIT) begin
                  stop_extra_nxt = stop2_lat;
                  state_nxt      = after_data;
               end else begin
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               stop_extra_nxt = stop2_lat;
               state_nxt      = STOP;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               if (stop_extra) begin
                  stop_extra_nxt = 1'b0;
               end else begin
                  frame_done = 1'b1;
                  // Chain straight into the next start bit when work is queued.
                  if (!fifo_empty) begin
                     pop       = 1'b1;
                     shift_nxt = mem[rd_ptr];
                     state_nxt = START;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      case (state_nxt)
         START:   tx_out_nxt = 1'b0;
         DATA:    tx_out_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  tx_out_nxt = par_bit;
`endif
         default: tx_out_nxt = 1'b1;
      endcase
   end

   assign tx_busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framed.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_framed : scoreboard bench with a frame-level reference model
// Revision 1.0
// ============================================================================
module tb_uart_tx_framed;

   localparam int DEPTH   = 4;
   localparam int BIT_CYC = 16;

   typedef struct {
      int          start;
      int          nbits;
      logic [15:0] bits;
   } frame_t;

   logic       clk        = 1'b0;
   logic       rst_n      = 1'b0;
   logic       tx_valid   = 1'b0;
   logic [7:0] tx_data    = '0;
   logic [1:0] cfg_parity = '0;
   logic       cfg_stop2  = 1'b0;
   logic       tx_ready;
   logic       tx_out;
   logic       tx_busy;
   logic       tx_complete;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0] mq[$];
   frame_t     exp_q[$];
   logic       m_busy     = 1'b0;
   logic       m_complete = 1'b0;
   int         m_end      = 0;
   int         m_level    = 0;
   logic       hist [256];

   uart_tx_framed #(
      .BAUD(100000),
      .SOURCE_FREQ(1600000),
      .ACCUMULATOR_WIDTH(16),
      .DATA_BITS(8),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .sourceClk(clk),
      .reset(rst_n),
      .tx_valid(tx_valid),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .cfg_parity(cfg_parity),
      .cfg_stop2(cfg_stop2),
      .tx_out(tx_out),
      .tx_busy(tx_busy),
      .tx_complete(tx_complete),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Builds the whole expected frame from the configuration seen at the pop edge.
   task automatic start_frame();
      frame_t     f;
      logic [7:0] w;
      int         n;
      w      = mq.pop_front();
      f.bits = '0;
      for (int i = 0; i < 8; i++) f.bits[1+i] = w[i];
      n = 9;
`ifdef UART_TX_PARITY_EN
      if (cfg_parity == 2'b01 || cfg_parity == 2'b10) begin
         f.bits[n] = (^w) ^ (cfg_parity == 2'b10);
         n++;
      end
`endif
      f.bits[n] = 1'b1;
      n++;
      if (cfg_stop2) begin
         f.bits[n] = 1'b1;
         n++;
      end
      f.start = cyc;
      f.nbits = n;
      exp_q.push_back(f);
      m_busy = 1'b1;
      m_end  = cyc + BIT_CYC * n;
   endtask

   always @(posedge clk) begin : model
      int sz;
      cyc        = cyc + 1;
      m_complete = 1'b0;
      if (!rst_n) begin
         mq.delete();
         exp_q.delete();
         m_busy = 1'b0;
      end else begin
         sz = mq.size();
         if (m_busy && cyc == m_end) begin
            m_complete = 1'b1;
            m_busy     = 1'b0;
         end
         if (!m_busy && sz > 0) start_frame();
         if (tx_valid && sz != DEPTH) mq.push_back(tx_data);
      end
      m_level = mq.size();
   end

   always @(negedge clk) begin : monitor
      frame_t f;
      int     mism;
      hist[cyc % 256] = tx_out;
      if (cyc > 0) begin
         check("tx_busy", tx_busy, m_busy);
         check("fifo_level", fifo_level, m_level);
         check("tx_ready", tx_ready, m_level != DEPTH);
         check("tx_complete", tx_complete, m_complete);
         if (!m_busy) check("idle_line", tx_out, 1);
         if (tx_complete === 1'b1) begin
            check("frame_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               f = exp_q.pop_front();
               check("frame_end_cycle", cyc, f.start + BIT_CYC * f.nbits);
               mism = 0;
               for (int i = 0; i < BIT_CYC * f.nbits; i++)
                  if (hist[(f.start + i) % 256] !== f.bits[i / BIT_CYC]) mism++;
               check("frame_bits", mism, 0);
            end
         end
      end
   end

   task automatic cyc_wait(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic write(input logic [7:0] d);
      tx_valid = 1'b1;
      tx_data  = d;
      cyc_wait(1);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int limit);
      int n = 0;
      while ((m_busy || mq.size() != 0 || tx_busy !== 1'b0) && n < limit) begin
         cyc_wait(1);
         n++;
      end
      check("drain_in_time", n < limit, 1);
   endtask

   initial begin
      cyc_wait(3);
      rst_n = 1'b1;
      cyc_wait(2);

      write(8'h55);
      wait_idle(400);

      cfg_parity = 2'b01;
      write(8'h07);
      wait_idle(400);
      cfg_parity = 2'b10;
      write(8'h03);
      wait_idle(400);

      cfg_parity = 2'b00;
      cfg_stop2  = 1'b1;
      write(8'hA3);
      wait_idle(400);
      cfg_stop2 = 1'b0;

      write(8'h11);
      write(8'h22);
      write(8'h33);
      write(8'h44);
      write(8'h55);
      check("burst_full_level", fifo_level, 4);
      check("burst_not_ready", tx_ready, 0);
      wait_idle(1500);

      write(8'hC6);
      write(8'h39);
      cyc_wait(39);
      cfg_parity = 2'b01;
      wait_idle(800);
      cfg_parity = 2'b00;

      write(8'h11);
      write(8'h22);
      write(8'h33);
      cyc_wait(70);
      rst_n = 1'b0;
      cyc_wait(1);
      check("reset_tx_out", tx_out, 1);
      check("reset_level", fifo_level, 0);
      check("reset_busy", tx_busy, 0);
      rst_n = 1'b1;
      cyc_wait(40);

      for (int i = 0; i < 2500; i++) begin
         tx_valid = ($urandom_range(0, 5) == 0);
         tx_data  = 8'($urandom);
         if ($urandom_range(0, 60) == 0) begin
            cfg_parity = 2'($urandom);
            cfg_stop2  = 1'($urandom);
         end
         cyc_wait(1);
      end
      tx_valid = 1'b0;
      wait_idle(3000);
      cyc_wait(2);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
